wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
Writeback stage plus architectural integer register file for the 5-stage RISC-V pipeline. It sits downstream of the MEM/WB pipeline register and consumes its latched writeback bundle: MemtoReg, RegWrite, rd, load data and ALU result. It selects the writeback value, commits it to x1..x31, and serves the two decode-stage read ports with same-cycle write-through bypass. It also keeps a retired-write counter for debug.

Parameters:
XLEN, 32, datapath width in bits.
NREG, 32, number of architectural registers; index width is clog2(NREG) = 5.
BYPASS, 1, when 1 a same-cycle writeback is forwarded to the read ports; when 0 reads return stored contents only.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  synchronous, active-low; clears state on a rising clk edge while low.
MemReadData_in  input  XLEN  load data from the MEM/WB register.
ALUResult_in  input  XLEN  ALU result from the MEM/WB register.
MemtoReg_in  input  1  1 selects MemReadData_in, 0 selects ALUResult_in.
RegWrite_in  input  1  writeback enable.
rd_in  input  5  destination register index.
rs1_addr  input  5  read port 1 index, driven by decode.
rs2_addr  input  5  read port 2 index, driven by decode.
dbg_addr  input  5  debug read index; never bypassed.
rs1_data  output  XLEN  read port 1 data, combinational.
rs2_data  output  XLEN  read port 2 data, combinational.
dbg_data  output  XLEN  debug read data, combinational, stored value only.
wb_data  output  XLEN  selected writeback value, combinational.
wb_we  output  1  qualified write strobe, combinational.
commit_count  output  32  registered count of qualified writes.

Behaviour:
- wb_data = MemtoReg_in ? MemReadData_in : ALUResult_in. This is pure combinational, with no dependency on reset.
- wb_we = reset & RegWrite_in & (rd_in != 0).
- Write: on a rising clk edge with wb_we=1, regs[rd_in] <= wb_data. Latency is 1 cycle to storage and 0 cycles through the bypass.
- x0 is hardwired to zero. Writes to x0 are discarded and not counted, and reading x0 on any port returns 0.
- Read port N (N = 1, 2):
  - If addr == 0, return 0.
  - Else if BYPASS=1, wb_we=1 and rd_in == addr, return wb_data.
  - Else return regs[addr].
- Both ports may hit the bypass in the same cycle, including rs1_addr == rs2_addr == rd_in.
- dbg_data returns regs[dbg_addr]; it returns 0 for index 0.
- Synchronous reset: on a rising edge with reset=0, regs[1..31] <= 0 and commit_count <= 0.
  - The reset overrides any write presented that cycle.
  - While reset=0, wb_we=0, so bypass is suppressed and reads return stored values, which are 0 after the first reset edge.
- Reset mid-operation: a write presented in the same cycle reset is low is lost. The first write after reset deasserts commits normally.
- commit_count increments by 1 on each edge with wb_we=1. It wraps from 0xFFFFFFFF to 0x00000000 with no flag.
- There are no stalls or flush inputs. Upstream must hold RegWrite_in=0 on bubbles, and every cycle with RegWrite_in=1 and rd_in!=0 is a retirement.
- Storage is 31 flops of XLEN bits, or a 2R1W array with write-through logic; implementation choice is free provided reads are combinational as specified.
- rd_in, rs1_addr, rs2_addr and dbg_addr are always in range (5 bits, NREG=32). No out-of-range handling is required.

Test Plan:
1. Reset and x0 writes:
   - Stimulus: hold reset=0 for 2 edges, release, read all 32 indices via dbg_addr. Then write 0xDEADBEEF to rd=0 with MemtoReg=0.
   - Required: every dbg_data=0 and commit_count=0; after the x0 write, dbg_data(0)=0 and commit_count stays 0.
2. Writeback mux select:
   - Stimulus: write rd=5 with ALUResult=0x00000011, MemRead=0x00000022, MemtoReg=0. Next cycle write rd=6 with the same data and MemtoReg=1.
   - Required: dbg(5)=0x11, dbg(6)=0x22, commit_count=2.
3. Same-cycle bypass:
   - Stimulus: x7 holds 0x1; present RegWrite=1, rd=7, ALUResult=0xCAFEF00D, rs1=rs2=7.
   - Required: rs1_data=rs2_data=0xCAFEF00D in the same cycle. With BYPASS=0 both return 0x1 until the edge.
4. Reset overrides write:
   - Stimulus: x9=0x55; assert reset=0 in the same cycle as a write of 0xAA to rd=9.
   - Required: after the edge dbg(9)=0, commit_count=0, and rs1_data(9)=0 during reset.
5. Back-to-back writes with RegWrite gating:
   - Stimulus: write rd=3 with values 1, 2, 3 on consecutive cycles, with RegWrite=0 on the third.
   - Required: dbg(3)=2, commit_count=2.
6. Counter wrap:
   - Stimulus: force commit_count to 0xFFFFFFFE, then perform 3 qualified writes.
   - Required: commit_count reads 0xFFFFFFFF, 0x00000000, 0x00000001 on successive edges.

Source files
------------

// File: rtl/wb_regfile_if.sv
// rtl/wb_regfile_if.sv - writeback bundle, read ports and debug bus for wb_regfile
interface wb_regfile_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] MemReadData_in;
    logic [XLEN-1:0] ALUResult_in;
    logic            MemtoReg_in;
    logic            RegWrite_in;
    logic [4:0]      rd_in;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [4:0]      dbg_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] dbg_data;
    logic [XLEN-1:0] wb_data;
    logic            wb_we;
    logic [31:0]     commit_count;

    modport slave (
        input  MemReadData_in, ALUResult_in, MemtoReg_in, RegWrite_in, rd_in,
        input  rs1_addr, rs2_addr, dbg_addr,
        output rs1_data, rs2_data, dbg_data, wb_data, wb_we, commit_count
    );

    modport master (
        output MemReadData_in, ALUResult_in, MemtoReg_in, RegWrite_in, rd_in,
        output rs1_addr, rs2_addr, dbg_addr,
        input  rs1_data, rs2_data, dbg_data, wb_data, wb_we, commit_count
    );
endinterface

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - writeback select, integer register file with write-through bypass, commit counter
module wb_regfile #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int BYPASS = 1
) (
    input  logic         clk,
    input  logic         reset,
    wb_regfile_if.slave  bus
);
    // Entry 0 is never written and is cleared on reset, so it always holds zero;
    // the read ports still force index 0 to zero explicitly.
    logic [XLEN-1:0] r_regs [0:NREG-1];
    logic [31:0]     r_commit_count;

    logic [XLEN-1:0] w_wb_data;
    logic            w_wb_we;
    logic [XLEN-1:0] w_rs1_data;
    logic [XLEN-1:0] w_rs2_data;
    logic [XLEN-1:0] w_dbg_data;

    // Writeback value select and qualified write strobe (reset blocks the strobe)
    always_comb begin
        w_wb_data = bus.MemtoReg_in ? bus.MemReadData_in : bus.ALUResult_in;
        w_wb_we   = reset & bus.RegWrite_in & (bus.rd_in != 5'd0);
    end

    // Register storage: reset clears everything and takes priority over a pending write
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wb_we) begin
            r_regs[bus.rd_in] <= w_wb_data;
        end
    end

    // Retired-write counter, free-running wrap
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_commit_count <= '0;
        end else if (w_wb_we) begin
            r_commit_count <= r_commit_count + 32'd1;
        end
    end

    // Read port 1: x0 is zero, a same-cycle write to the same index is forwarded
    always_comb begin
        w_rs1_data = r_regs[bus.rs1_addr];
        if (bus.rs1_addr == 5'd0) begin
            w_rs1_data = '0;
        end else if ((BYPASS != 0) && w_wb_we && (bus.rd_in == bus.rs1_addr)) begin
            w_rs1_data = w_wb_data;
        end
    end

    // Read port 2: same rules as port 1, independent so both may forward at once
    always_comb begin
        w_rs2_data = r_regs[bus.rs2_addr];
        if (bus.rs2_addr == 5'd0) begin
            w_rs2_data = '0;
        end else if ((BYPASS != 0) && w_wb_we && (bus.rd_in == bus.rs2_addr)) begin
            w_rs2_data = w_wb_data;
        end
    end

    // Debug port shows committed state only, never the in-flight write
    always_comb begin
        w_dbg_data = r_regs[bus.dbg_addr];
        if (bus.dbg_addr == 5'd0) begin
            w_dbg_data = '0;
        end
    end

    assign bus.wb_data      = w_wb_data;
    assign bus.wb_we        = w_wb_we;
    assign bus.rs1_data     = w_rs1_data;
    assign bus.rs2_data     = w_rs2_data;
    assign bus.dbg_data     = w_dbg_data;
    assign bus.commit_count = r_commit_count;
endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - scoreboard bench for wb_regfile with and without bypass
module tb_wb_regfile;
    logic clk;
    logic reset;

    wb_regfile_if #(.XLEN(32)) bus_a ();
    wb_regfile_if #(.XLEN(32)) bus_b ();

    wb_regfile #(.XLEN(32), .NREG(32), .BYPASS(1)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    wb_regfile #(.XLEN(32), .NREG(32), .BYPASS(0)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    assign bus_b.MemReadData_in = bus_a.MemReadData_in;
    assign bus_b.ALUResult_in   = bus_a.ALUResult_in;
    assign bus_b.MemtoReg_in    = bus_a.MemtoReg_in;
    assign bus_b.RegWrite_in    = bus_a.RegWrite_in;
    assign bus_b.rd_in          = bus_a.rd_in;
    assign bus_b.rs1_addr       = bus_a.rs1_addr;
    assign bus_b.rs2_addr       = bus_a.rs2_addr;
    assign bus_b.dbg_addr       = bus_a.dbg_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int S_RS1   = 0;
    localparam int S_RS2   = 1;
    localparam int S_DBG   = 2;
    localparam int S_WBD   = 3;
    localparam int S_WE    = 4;
    localparam int S_CNT   = 5;
    localparam int S_RS1_B = 6;
    localparam int S_RS2_B = 7;
    localparam int S_DBG_B = 8;
    localparam int S_CNT_B = 9;

    typedef struct {
        string       tag;
        int          src;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_total = 0;
    int   n_bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int src);
        case (src)
            S_RS1:   return bus_a.rs1_data;
            S_RS2:   return bus_a.rs2_data;
            S_DBG:   return bus_a.dbg_data;
            S_WBD:   return bus_a.wb_data;
            S_WE:    return {31'd0, bus_a.wb_we};
            S_CNT:   return bus_a.commit_count;
            S_RS1_B: return bus_b.rs1_data;
            S_RS2_B: return bus_b.rs2_data;
            S_DBG_B: return bus_b.dbg_data;
            S_CNT_B: return bus_b.commit_count;
            default: return 32'hxxxx_xxxx;
        endcase
    endfunction

    task automatic expect_val(input string tag, input int src, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.src = src;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic drain;
        exp_t e;
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val(e.tag, observe(e.src), e.exp);
        end
    endtask

    task automatic drive(input logic we, input logic mtr, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] mem);
        bus_a.RegWrite_in    = we;
        bus_a.MemtoReg_in    = mtr;
        bus_a.rd_in          = rd;
        bus_a.ALUResult_in   = alu;
        bus_a.MemReadData_in = mem;
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic dbg_expect(input string tag, input logic [4:0] idx, input logic [31:0] exp);
        bus_a.dbg_addr = idx;
        expect_val(tag, S_DBG, exp);
        expect_val({tag, "_nb"}, S_DBG_B, exp);
        drain();
    endtask

    initial begin
        reset          = 1'b0;
        bus_a.rs1_addr = 5'd0;
        bus_a.rs2_addr = 5'd0;
        bus_a.dbg_addr = 5'd0;
        drive(1'b1, 1'b0, 5'd1, 32'h1234_5678, 32'h0);
        @(negedge clk);
        expect_val("we_in_reset", S_WE, 32'd0);
        drain();
        tick();
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        reset = 1'b1;

        // Reset state of every index and the counter
        for (int i = 0; i < 32; i++) begin
            bus_a.dbg_addr = i[4:0];
            expect_val($sformatf("rst_dbg%0d", i), S_DBG, 32'd0);
            drain();
        end
        expect_val("rst_cnt", S_CNT, 32'd0);
        drain();

        // Write to x0 is discarded and uncounted
        drive(1'b1, 1'b0, 5'd0, 32'hDEAD_BEEF, 32'h0);
        expect_val("x0_we", S_WE, 32'd0);
        expect_val("x0_wbd", S_WBD, 32'hDEAD_BEEF);
        drain();
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        dbg_expect("x0_dbg", 5'd0, 32'd0);
        bus_a.rs1_addr = 5'd0;
        expect_val("x0_rs1", S_RS1, 32'd0);
        expect_val("x0_cnt", S_CNT, 32'd0);
        drain();

        // Writeback mux select
        drive(1'b1, 1'b0, 5'd5, 32'h0000_0011, 32'h0000_0022);
        expect_val("mux_alu", S_WBD, 32'h11);
        drain();
        tick();
        drive(1'b1, 1'b1, 5'd6, 32'h0000_0011, 32'h0000_0022);
        expect_val("mux_mem", S_WBD, 32'h22);
        drain();
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        dbg_expect("mux_dbg5", 5'd5, 32'h11);
        dbg_expect("mux_dbg6", 5'd6, 32'h22);
        expect_val("mux_cnt", S_CNT, 32'd2);
        drain();

        // Same-cycle bypass on both ports, absent when BYPASS=0
        drive(1'b1, 1'b0, 5'd7, 32'h0000_0001, 32'h0);
        tick();
        drive(1'b1, 1'b0, 5'd7, 32'hCAFE_F00D, 32'h0);
        bus_a.rs1_addr = 5'd7;
        bus_a.rs2_addr = 5'd7;
        bus_a.dbg_addr = 5'd7;
        expect_val("byp_rs1", S_RS1, 32'hCAFE_F00D);
        expect_val("byp_rs2", S_RS2, 32'hCAFE_F00D);
        expect_val("nobyp_rs1", S_RS1_B, 32'h1);
        expect_val("nobyp_rs2", S_RS2_B, 32'h1);
        expect_val("byp_dbg_old", S_DBG, 32'h1);
        drain();
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        expect_val("byp_after_b", S_RS1_B, 32'hCAFE_F00D);
        expect_val("byp_cnt", S_CNT, 32'd4);
        drain();
        dbg_expect("byp_dbg7", 5'd7, 32'hCAFE_F00D);

        // Reset overrides a same-cycle write
        drive(1'b1, 1'b0, 5'd9, 32'h0000_0055, 32'h0);
        tick();
        reset = 1'b0;
        drive(1'b1, 1'b0, 5'd9, 32'h0000_00AA, 32'h0);
        bus_a.rs1_addr = 5'd9;
        expect_val("rstw_we", S_WE, 32'd0);
        expect_val("rstw_rs1_pre", S_RS1, 32'h55);
        drain();
        tick();
        expect_val("rstw_rs1", S_RS1, 32'd0);
        expect_val("rstw_cnt", S_CNT, 32'd0);
        expect_val("rstw_cnt_nb", S_CNT_B, 32'd0);
        drain();
        dbg_expect("rstw_dbg9", 5'd9, 32'd0);
        reset = 1'b1;

        // Back-to-back writes, third one not enabled
        drive(1'b1, 1'b0, 5'd3, 32'd1, 32'h0);
        tick();
        drive(1'b1, 1'b0, 5'd3, 32'd2, 32'h0);
        tick();
        drive(1'b0, 1'b0, 5'd3, 32'd3, 32'h0);
        bus_a.rs1_addr = 5'd3;
        expect_val("b2b_rs1_gated", S_RS1, 32'd2);
        drain();
        tick();
        dbg_expect("b2b_dbg3", 5'd3, 32'd2);
        expect_val("b2b_cnt", S_CNT, 32'd2);
        drain();

        // Counter wrap from a preloaded value
        force dut_a.r_commit_count = 32'hFFFF_FFFE;
        #1;
        release dut_a.r_commit_count;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 5'd10, 32'(k + 100), 32'h0);
            tick();
            expect_val($sformatf("wrap%0d", k), S_CNT, 32'hFFFF_FFFF + 32'(k));
            drain();
        end
        drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        dbg_expect("wrap_dbg10", 5'd10, 32'd102);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end
endmodule
